// File: rtl/emd_pkg.sv
// Shared EMD sifting-chain types: default widths, the extremum record and the
// output state encoding.
package emd_pkg;

   localparam int EMD_SMP_W  = 16;
   localparam int EMD_TIME_W = 16;

   typedef struct packed {
      logic [EMD_TIME_W-1:0]        time_idx;
      logic signed [EMD_SMP_W-1:0]  val;
      logic                         last;
   } emd_ext_rec_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HAVE  = 1'b1
   } emd_st_e;

endpackage

// File: rtl/emd_extrema_fifo_if.sv
// Extremum capture inputs and record output bus. Handshake: a record transfers
// on any rising edge where OUT_VALID and OUT_READY are both high; no upstream back-pressure.
interface emd_extrema_fifo_if #(
   parameter int TIME_W = 16,
   parameter int SMP_W  = 16
);
   logic                     SEG_START;
   logic                     TRG;
   logic [TIME_W-1:0]        TIME;
   logic signed [SMP_W-1:0]  VAL;
   logic                     SEG_END;
   logic                     OUT_VALID;
   logic                     OUT_READY;
   logic [TIME_W-1:0]        OUT_TIME;
   logic signed [SMP_W-1:0]  OUT_VAL;
   logic                     OUT_LAST;
   logic [TIME_W-1:0]        EXT_CNT;
   logic                     OVF;

   modport master (
      output SEG_START, TRG, TIME, VAL, SEG_END, OUT_READY,
      input  OUT_VALID, OUT_TIME, OUT_VAL, OUT_LAST, EXT_CNT, OVF
   );

   modport slave (
      input  SEG_START, TRG, TIME, VAL, SEG_END, OUT_READY,
      output OUT_VALID, OUT_TIME, OUT_VAL, OUT_LAST, EXT_CNT, OVF
   );
endinterface

// File: rtl/emd_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count only.
// o_rdata shows the entry that will be at the head after this edge's pop.
module emd_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 33
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_rdata = r_mem[w_pop ? (r_rptr + AW'(1)) : r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/emd_extrema_fifo.sv
// Captures extremum/endpoint records into a FIFO and presents them with
// registered head outputs; tracks per-segment record count and overflow.
module emd_extrema_fifo
   import emd_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int SMP_W  = EMD_SMP_W,
   parameter int TIME_W = EMD_TIME_W
) (
   input  logic                CLK,
   input  logic                RST_N,
   emd_extrema_fifo_if.slave   bus,
   output emd_st_e             o_st
);
   localparam int RW = TIME_W + SMP_W + 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [RW-1:0]            w_wdata;
   logic [RW-1:0]            w_rdata;
   logic [RW-1:0]            w_head_nxt;
   logic [CW-1:0]            w_count;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_dup;
   logic                     w_req;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_drop;
   logic                     w_load;
   logic [TIME_W-1:0]        w_ext_base;

   emd_st_e                  r_st;
   logic [TIME_W-1:0]        r_out_time;
   logic signed [SMP_W-1:0]  r_out_val;
   logic                     r_out_last;
   logic [TIME_W-1:0]        r_ext_cnt;
   logic                     r_ovf;
   logic                     r_dup_ok;
   logic [TIME_W-1:0]        r_last_time;

   // SEG_START clears dup_ok before this edge's push is judged.
   assign w_dup      = bus.TRG & ~bus.SEG_END & r_dup_ok & ~bus.SEG_START &
                       (bus.TIME == r_last_time);
   assign w_req      = (bus.TRG | bus.SEG_END) & ~w_dup;
   assign w_pop      = (r_st == ST_HAVE) & bus.OUT_READY;
   assign w_push     = w_req & (~w_full | w_pop);
   assign w_drop     = w_req & w_full & ~w_pop;
   assign w_wdata    = {bus.TIME, bus.VAL, bus.SEG_END};
   assign w_ext_base = bus.SEG_START ? '0 : r_ext_cnt;

   // Head reloads only when the FIFO is non-empty after this edge.
   assign w_load     = w_pop ? ((w_count > CW'(1)) | w_push) : (w_push & w_empty);
   assign w_head_nxt = (w_pop && (w_count > CW'(1))) ? w_rdata : w_wdata;

   emd_sync_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_st        <= ST_EMPTY;
         r_out_time  <= '0;
         r_out_val   <= '0;
         r_out_last  <= 1'b0;
         r_ext_cnt   <= '0;
         r_ovf       <= 1'b0;
         r_dup_ok    <= 1'b0;
         r_last_time <= '0;
      end else begin
         case (r_st)
            ST_EMPTY: if (w_push) r_st <= ST_HAVE;
            ST_HAVE:  if (w_pop && (w_count == CW'(1)) && !w_push) r_st <= ST_EMPTY;
         endcase
         if (w_load) {r_out_time, r_out_val, r_out_last} <= w_head_nxt;
         if (w_push)
            r_ext_cnt <= (w_ext_base == '1) ? w_ext_base : w_ext_base + TIME_W'(1);
         else if (bus.SEG_START)
            r_ext_cnt <= '0;
         r_ovf <= (r_ovf & ~bus.SEG_START) | w_drop;
         if (w_push) begin
            r_last_time <= bus.TIME;
            r_dup_ok    <= ~bus.SEG_END;
         end else if (bus.SEG_START) begin
            r_dup_ok    <= 1'b0;
         end
      end
   end

   assign bus.OUT_VALID = (r_st == ST_HAVE);
   assign bus.OUT_TIME  = r_out_time;
   assign bus.OUT_VAL   = r_out_val;
   assign bus.OUT_LAST  = r_out_last;
   assign bus.EXT_CNT   = r_ext_cnt;
   assign bus.OVF       = r_ovf;
   assign o_st          = r_st;
endmodule

// File: tb/tb_emd_extrema_fifo.sv
// Directed bench for emd_extrema_fifo: hand-computed records checked through
// an expected-record queue, plus flag/count checks at the boundary cases.
module tb_emd_extrema_fifo;
   import emd_pkg::*;

   localparam int REC_W = $bits(emd_ext_rec_t);

   logic    clk;
   logic    rst_n;
   emd_st_e st;
   int      n_vec;
   int      n_err;
   logic [REC_W-1:0] exp_q[$];

   emd_extrema_fifo_if #(.TIME_W(16), .SMP_W(16)) bus ();

   emd_extrema_fifo #(.DEPTH(16), .SMP_W(16), .TIME_W(16)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus),
      .o_st  (st)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.SEG_START = 1'b0;
      bus.TRG       = 1'b0;
      bus.SEG_END   = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic seg_start();
      bus.SEG_START = 1'b1;
      tick();
      idle();
   endtask

   task automatic trg(input logic [15:0] t, input logic signed [15:0] v);
      bus.TRG  = 1'b1;
      bus.TIME = t;
      bus.VAL  = v;
      tick();
      idle();
   endtask

   task automatic expect_rec(input logic [15:0] t, input logic signed [15:0] v, input logic l);
      emd_ext_rec_t r;
      r.time_idx = t;
      r.val      = v;
      r.last     = l;
      exp_q.push_back(REC_W'(r));
   endtask

   // scoreboard: pop one expected record per cycle while OUT_READY is high
   task automatic drain();
      emd_ext_rec_t r;
      bus.OUT_READY = 1'b1;
      while (exp_q.size() > 0) begin
         r = emd_ext_rec_t'(exp_q.pop_front());
         chk("drain_valid", 32'(bus.OUT_VALID), 32'd1);
         chk("drain_time",  32'(bus.OUT_TIME),  32'(r.time_idx));
         chk("drain_val",   32'(bus.OUT_VAL),   32'(r.val));
         chk("drain_last",  32'(bus.OUT_LAST),  32'(r.last));
         tick();
      end
      bus.OUT_READY = 1'b0;
      chk("drain_empty", 32'(bus.OUT_VALID), 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      bus.TIME      = '0;
      bus.VAL       = '0;
      bus.OUT_READY = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
      chk("rst_time",  32'(bus.OUT_TIME),  32'd0);
      chk("rst_val",   32'(bus.OUT_VAL),   32'd0);
      chk("rst_last",  32'(bus.OUT_LAST),  32'd0);
      chk("rst_cnt",   32'(bus.EXT_CNT),   32'd0);
      chk("rst_ovf",   32'(bus.OVF),       32'd0);
      chk("rst_st",    32'(st),            32'(ST_EMPTY));
      rst_n = 1'b1;

      // two records streamed with OUT_READY high
      seg_start();
      bus.OUT_READY = 1'b1;
      trg(16'd5, 16'sd100);
      chk("s1_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("s1_time",  32'(bus.OUT_TIME),  32'd5);
      chk("s1_val",   32'(bus.OUT_VAL),   32'(16'sd100));
      chk("s1_last",  32'(bus.OUT_LAST),  32'd0);
      chk("s1_st",    32'(st),            32'(ST_HAVE));
      trg(16'd9, -16'sd40);
      chk("s2_time",  32'(bus.OUT_TIME),  32'd9);
      chk("s2_val",   32'(bus.OUT_VAL),   32'(-16'sd40));
      chk("s2_last",  32'(bus.OUT_LAST),  32'd0);
      tick();
      chk("s2_empty", 32'(bus.OUT_VALID), 32'd0);
      chk("s2_cnt",   32'(bus.EXT_CNT),   32'd2);
      bus.OUT_READY = 1'b0;

      // repeated trigger on one sample, then segment endpoint at the same time
      seg_start();
      bus.TRG  = 1'b1;
      bus.TIME = 16'd7;
      bus.VAL  = 16'sd55;
      tick();
      tick();
      tick();
      idle();
      chk("dup_cnt", 32'(bus.EXT_CNT), 32'd1);
      bus.SEG_END = 1'b1;
      bus.VAL     = 16'sd56;
      tick();
      idle();
      chk("end_cnt", 32'(bus.EXT_CNT), 32'd2);
      expect_rec(16'd7, 16'sd55, 1'b0);
      expect_rec(16'd7, 16'sd56, 1'b1);
      drain();

      // overflow: 17 events into 16 entries
      seg_start();
      for (int i = 0; i < 17; i++) begin
         trg(16'(100 + i), 16'(i * 3 - 20));
         if (i < 16) expect_rec(16'(100 + i), 16'(i * 3 - 20), 1'b0);
      end
      chk("ovf_flag", 32'(bus.OVF),     32'd1);
      chk("ovf_cnt",  32'(bus.EXT_CNT), 32'd16);
      drain();

      // full FIFO with simultaneous push and pop
      seg_start();
      for (int i = 0; i < 16; i++) begin
         trg(16'(200 + i), 16'(i));
         expect_rec(16'(200 + i), 16'(i), 1'b0);
      end
      chk("full_ovf0", 32'(bus.OVF),      32'd0);
      chk("full_head", 32'(bus.OUT_TIME), 32'd200);
      void'(exp_q.pop_front());
      bus.OUT_READY = 1'b1;
      trg(16'd216, 16'sd7);
      bus.OUT_READY = 1'b0;
      expect_rec(16'd216, 16'sd7, 1'b0);
      chk("pp_ovf",  32'(bus.OVF),      32'd0);
      chk("pp_cnt",  32'(bus.EXT_CNT),  32'd17);
      chk("pp_head", 32'(bus.OUT_TIME), 32'd201);
      trg(16'd300, 16'sd1);
      chk("pp_still_full", 32'(bus.OVF),     32'd1);
      chk("pp_drop_cnt",   32'(bus.EXT_CNT), 32'd17);
      drain();

      // SEG_START, TRG and SEG_END together: one endpoint record, count restarts at 1
      bus.SEG_START = 1'b1;
      bus.SEG_END   = 1'b1;
      trg(16'd30, 16'sd12);
      chk("both_cnt", 32'(bus.EXT_CNT), 32'd1);
      chk("both_ovf", 32'(bus.OVF),     32'd0);
      expect_rec(16'd30, 16'sd12, 1'b1);
      drain();

      // reset with records queued
      seg_start();
      for (int i = 0; i < 5; i++) trg(16'(40 + i), 16'(i));
      chk("pre_rst_cnt", 32'(bus.EXT_CNT), 32'd5);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
      chk("mid_rst_cnt",   32'(bus.EXT_CNT),   32'd0);
      trg(16'd50, -16'sd1);
      chk("post_rst_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("post_rst_cnt",   32'(bus.EXT_CNT),   32'd1);
      expect_rec(16'd50, -16'sd1, 1'b0);
      drain();

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
